// File: rtl/fnd_scan_controller.sv
// Four-digit FND scan controller: drives one BCD digit at a time into a shared
// decoder, with all-off dead time between digits and per-digit blank/blink.
module fnd_scan_controller #(
  parameter int unsigned SCAN_DIV    = 100_000,
  parameter int unsigned DEAD_CYCLES = 1_000,
  parameter int unsigned BLINK_DIV   = 125
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [15:0] i_digits,
  input  logic [3:0]  i_blank_mask,
  input  logic [3:0]  i_blink_mask,
  output logic [3:0]  o_digit_sel,
  output logic [3:0]  o_value,
  output logic        o_blank
);

  // Guard against zero-width counters when a parameter is 1.
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PrescLast = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DeadLast  = DW'(DEAD_CYCLES - 1);
  localparam logic [BW-1:0] ScanLast  = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StDead} state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [BW-1:0] scan_q, scan_d;
  logic          phase_q, phase_d;
  logic [3:0]    sel_q, sel_d;
  logic [3:0]    value_q, value_d;
  logic          blank_q, blank_d;

  logic          enter_drive;
  logic [1:0]    next_idx;

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      presc_q <= '0;
      dead_q  <= '0;
      scan_q  <= '0;
      phase_q <= 1'b0;
      sel_q   <= 4'b1111;
      value_q <= 4'h0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      dead_q  <= dead_d;
      scan_q  <= scan_d;
      phase_q <= phase_d;
      sel_q   <= sel_d;
      value_q <= value_d;
      blank_q <= blank_d;
    end
  end

  // Next-state logic; outputs are computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    presc_d     = presc_q;
    dead_d      = dead_q;
    scan_d      = scan_q;
    phase_d     = phase_q;
    sel_d       = sel_q;
    value_d     = value_q;
    blank_d     = blank_q;
    enter_drive = 1'b0;
    next_idx    = 2'd0;

    if (state_q != StIdle && !i_enable) begin
      // Disable: go dark, clear position, keep the blink phase.
      state_d = StIdle;
      idx_d   = '0;
      presc_d = '0;
      dead_d  = '0;
      scan_d  = '0;
      sel_d   = 4'b1111;
      value_d = 4'h0;
      blank_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_enable) begin
            enter_drive = 1'b1;
            next_idx    = 2'd0;
          end
        end
        StDrive: begin
          if (presc_q == PrescLast) begin
            state_d = StDead;
            presc_d = '0;
            dead_d  = '0;
            sel_d   = 4'b1111;
            blank_d = 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        StDead: begin
          if (dead_q == DeadLast) begin
            enter_drive = 1'b1;
            next_idx    = idx_q + 2'd1;
            // A full scan completes when digit 3 hands back to digit 0.
            if (idx_q == 2'd3) begin
              if (scan_q == ScanLast) begin
                scan_d  = '0;
                phase_d = ~phase_q;
              end else begin
                scan_d = scan_q + 1'b1;
              end
            end
          end else begin
            dead_d = dead_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // Entry into DRIVE latches the digit and its blank flag using the new phase.
    if (enter_drive) begin
      state_d = StDrive;
      idx_d   = next_idx;
      presc_d = '0;
      dead_d  = '0;
      sel_d   = ~(4'b0001 << next_idx);
      value_d = i_digits[{next_idx, 2'b00} +: 4];
      blank_d = i_blank_mask[next_idx] | (i_blink_mask[next_idx] & phase_d);
    end
  end

  assign o_digit_sel = sel_q;
  assign o_value     = value_q;
  assign o_blank     = blank_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller with small scan/dead/blink dividers.
module tb_fnd_scan_controller;

  localparam int unsigned SD = 4;
  localparam int unsigned DC = 2;
  localparam int unsigned BD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic [3:0]  digit_sel;
  logic [3:0]  value;
  logic        blank;

  int n_cmp = 0;
  int n_err = 0;

  // Expected {sel, value, blank} per clock cycle.
  logic [8:0] sb_q[$];

  fnd_scan_controller #(
    .SCAN_DIV   (SD),
    .DEAD_CYCLES(DC),
    .BLINK_DIV  (BD)
  ) u_dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_enable    (en),
    .i_digits    (digits),
    .i_blank_mask(blank_mask),
    .i_blink_mask(blink_mask),
    .o_digit_sel (digit_sel),
    .o_value     (value),
    .o_blank     (blank)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got sel=%b val=%h blank=%b, want sel=%b val=%h blank=%b",
               tag, $time, got[8:5], got[4:1], got[0], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic push_slot(input int n, input logic [3:0] val, input logic blk);
    logic [3:0] sel;
    sel = ~(4'b0001 << n);
    repeat (SD) sb_q.push_back({sel, val, blk});
    repeat (DC) sb_q.push_back({4'b1111, val, 1'b1});
  endtask

  task automatic push_scan(input logic [15:0] d, input logic [3:0] bm, input logic [3:0] km,
                           input logic ph);
    for (int n = 0; n < 4; n++) push_slot(n, d[4*n +: 4], bm[n] | (km[n] & ph));
  endtask

  // Advance one clock and compare against the oldest expectation.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_underflow"}, {digit_sel, value, blank}, 9'bx);
    end else begin
      check_eq(tag, {digit_sel, value, blank}, sb_q.pop_front());
    end
  endtask

  task automatic drain_n(input string tag, input int k);
    for (int i = 0; i < k && sb_q.size() > 0; i++) step(tag);
  endtask

  task automatic drain(input string tag);
    while (sb_q.size() > 0) step(tag);
  endtask

  task automatic do_reset();
    en         = 1'b0;
    digits     = 16'h1234;
    blank_mask = 4'b0000;
    blink_mask = 4'b0000;
    sb_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_eq("reset", {digit_sel, value, blank}, {4'b1111, 4'h0, 1'b1});
    #2 rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    digits     = 16'h0;
    blank_mask = 4'b0;
    blink_mask = 4'b0;
    #12;

    // Basic scan order, timing and wrap at cycle 24.
    do_reset();
    en = 1'b1;
    push_scan(16'h1234, 4'b0000, 4'b0000, 1'b0);
    push_scan(16'h1234, 4'b0000, 4'b0000, 1'b0);
    drain("scan");

    // Asynchronous reset in the middle of a DEAD interval.
    repeat (SD) sb_q.push_back({4'b1110, 4'h4, 1'b0});
    sb_q.push_back({4'b1111, 4'h4, 1'b1});
    drain("pre_async");
    rst = 1'b1;
    #1 check_eq("async_reset", {digit_sel, value, blank}, {4'b1111, 4'h0, 1'b1});
    en = 1'b0;
    #2 rst = 1'b0;

    // Blank mask on digit 3.
    do_reset();
    blank_mask = 4'b1000;
    en         = 1'b1;
    push_scan(16'h1234, 4'b1000, 4'b0000, 1'b0);
    drain("blank");

    // Blink on digit 0: phase toggles every BD scans.
    do_reset();
    blink_mask = 4'b0001;
    en         = 1'b1;
    for (int s = 0; s < 6; s++) push_scan(16'h1234, 4'b0000, 4'b0001, logic'((s / BD) % 2));
    drain("blink");

    // Digit change mid-DRIVE is not seen until the next slot.
    do_reset();
    en = 1'b1;
    push_slot(0, 4'h4, 1'b0);
    push_slot(1, 4'h7, 1'b0);
    push_slot(2, 4'h6, 1'b0);
    push_slot(3, 4'h5, 1'b0);
    drain_n("latch", 2);
    digits = 16'h5678;
    drain("latch");

    // Disable mid-DRIVE goes dark next edge; re-enable restarts at digit 0.
    do_reset();
    en = 1'b1;
    repeat (2) sb_q.push_back({4'b1110, 4'h4, 1'b0});
    drain("pre_disable");
    en = 1'b0;
    sb_q.push_back({4'b1111, 4'h0, 1'b1});
    sb_q.push_back({4'b1111, 4'h0, 1'b1});
    drain("disable");
    en = 1'b1;
    push_slot(0, 4'h4, 1'b0);
    push_slot(1, 4'h3, 1'b0);
    drain("reenable");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
